// File: rtl/counter_arb_pkg.sv
// Purpose: shared types and constants for the counter arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package counter_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam int REQ_UP    = 0;
    localparam int REQ_DN    = 1;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LEN_W = 4;

endpackage

// File: rtl/counter_core.sv
// Purpose: WIDTH-bit up/down counter register; steps by one when en is high.
// Latency: count updates on the edge after en/dir are presented.
// Backpressure: none; en is the only hold control.
//
// Ports: clk, reset (sync, active-high), en (step enable), dir (1=up, 0=down),
//        count (current value).
// Build option: COUNTER_ARB_SAT_EN selects saturating arithmetic instead of
//               modulo wrap.
module counter_core #(
    parameter int WIDTH = counter_arb_pkg::DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_nxt;

    always_comb begin
        count_nxt = count;
        if (en) begin
`ifdef COUNTER_ARB_SAT_EN
            // Clamp at the rails instead of wrapping.
            if (dir && (count != {WIDTH{1'b1}}))
                count_nxt = count + WIDTH'(1);
            else if (!dir && (count != '0))
                count_nxt = count - WIDTH'(1);
`else
            count_nxt = dir ? (count + WIDTH'(1)) : (count - WIDTH'(1));
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else
            count <= count_nxt;
    end

endmodule

// File: rtl/counter_arbiter.sv
// Purpose: round-robin share of one up/down counter between an up and a down requester.
// Latency: grant one edge after req; N steps on the next N edges; done in the cycle after.
// Backpressure: requester holds req until done; dropping req mid-burst aborts it.
//
// Ports: clk, reset (sync, active-high), req[1:0] (0=up, 1=down), len0/len1
//        (burst lengths sampled at grant), grant (one-hot), busy (RUN or DONE),
//        done (one-cycle completion pulse), count (shared counter value).
// Build option: COUNTER_ARB_SAT_EN makes the count saturate (handled in counter_core).
module counter_arbiter
    import counter_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic [1:0]       grant,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count
);

    arb_state_t       state, state_nxt;
    logic [1:0]       grant_nxt;
    logic [LEN_W-1:0] remaining, remaining_nxt;
    logic             last, last_nxt;
    logic             win;
    logic [LEN_W-1:0] win_len;
    logic             gidx;
    logic             granted_req;

    // Index of the current owner and whether it is still asking.
    assign gidx        = grant[REQ_DN];
    assign granted_req = |(req & grant);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= 2'b00;
            remaining <= '0;
            last      <= 1'b1;   // requester 0 wins the first contention
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            remaining <= remaining_nxt;
            last      <= last_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        remaining_nxt = remaining;
        last_nxt      = last;
        win           = 1'b0;
        win_len       = len0;
        case (state)
            IDLE: begin
                if (|req) begin
                    // On contention the requester that was not served last wins.
                    win           = (req[REQ_UP] && (!req[REQ_DN] || last)) ? 1'b0 : 1'b1;
                    win_len       = win ? len1 : len0;
                    grant_nxt     = win ? 2'b10 : 2'b01;
                    remaining_nxt = win_len;
                    state_nxt     = (win_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (!granted_req) begin
                    // Owner withdrew: release without stepping and without done.
                    state_nxt = IDLE;
                    grant_nxt = 2'b00;
                    last_nxt  = gidx;
                end else begin
                    remaining_nxt = remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1))
                        state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                grant_nxt = 2'b00;
                last_nxt  = gidx;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 2'b00;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    counter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .en    ((state == RUN) && granted_req),
        .dir   (grant[REQ_UP]),
        .count (count)
    );

endmodule

// File: tb/tb_counter_arbiter.sv
// Purpose: directed self-checking bench for counter_arbiter.
// Latency: checks every cycle, sampled 1 time unit after the rising edge.
// Backpressure: n/a.
module tb_counter_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [3:0] len0, len1;
    logic [1:0] grant;
    logic       busy, done;
    logic [7:0] count;
    logic [11:0] obs;

    int checks   = 0;
    int failures = 0;

    counter_arbiter #(.WIDTH(8), .LEN_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len0  (len0),
        .len1  (len1),
        .grant (grant),
        .busy  (busy),
        .done  (done),
        .count (count)
    );

    always #5 clk = ~clk;

    assign obs = {grant, busy, done, count};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 2'b00;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 2'b11;
        len0  = 4'd5;
        len1  = 4'd5;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs !== 12'h000) begin
                failures++;
                $display("FAIL reset[%0d] got=%h want=%h", i, obs, 12'h000);
            end
        end
        reset = 1'b0;
        req   = 2'b00;
    endtask

    task automatic test_single_up();
        logic [1:0]  rq [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
        logic [11:0] ex [6] = '{{2'b01,1'b1,1'b0,8'd0}, {2'b01,1'b1,1'b0,8'd1},
                                {2'b01,1'b1,1'b0,8'd2}, {2'b01,1'b1,1'b1,8'd3},
                                {2'b00,1'b0,1'b0,8'd3}, {2'b00,1'b0,1'b0,8'd3}};
        do_reset();
        len0 = 4'd3;
        len1 = 4'd7;
        for (int i = 0; i < 6; i++) begin
            req = rq[i];
            tick();
            checks++;
            if (obs !== ex[i]) begin
                failures++;
                $display("FAIL single_up[%0d] got=%h want=%h", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_fairness();
        logic [11:0] ex [10] = '{{2'b01,1'b1,1'b0,8'd0}, {2'b01,1'b1,1'b0,8'd1},
                                 {2'b01,1'b1,1'b1,8'd2}, {2'b00,1'b0,1'b0,8'd2},
                                 {2'b10,1'b1,1'b0,8'd2}, {2'b10,1'b1,1'b0,8'd1},
                                 {2'b10,1'b1,1'b1,8'd0}, {2'b00,1'b0,1'b0,8'd0},
                                 {2'b01,1'b1,1'b0,8'd0}, {2'b00,1'b0,1'b0,8'd0}};
        do_reset();
        len0 = 4'd2;
        len1 = 4'd2;
        for (int i = 0; i < 10; i++) begin
            req = (i == 9) ? 2'b00 : 2'b11;
            tick();
            checks++;
            if (obs !== ex[i]) begin
                failures++;
                $display("FAIL fairness[%0d] got=%h want=%h", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [1:0]  rq [4] = '{2'b10, 2'b10, 2'b10, 2'b00};
`ifdef COUNTER_ARB_SAT_EN
        logic [11:0] ex [4] = '{{2'b10,1'b1,1'b0,8'd0}, {2'b10,1'b1,1'b0,8'd0},
                                {2'b10,1'b1,1'b1,8'd0}, {2'b00,1'b0,1'b0,8'd0}};
`else
        logic [11:0] ex [4] = '{{2'b10,1'b1,1'b0,8'd0},   {2'b10,1'b1,1'b0,8'd255},
                                {2'b10,1'b1,1'b1,8'd254}, {2'b00,1'b0,1'b0,8'd254}};
`endif
        do_reset();
        len0 = 4'd9;
        len1 = 4'd2;
        for (int i = 0; i < 4; i++) begin
            req = rq[i];
            tick();
            checks++;
            if (obs !== ex[i]) begin
                failures++;
                $display("FAIL wrap[%0d] got=%h want=%h", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_zero_len();
        logic [1:0]  rq [3] = '{2'b01, 2'b00, 2'b00};
        logic [11:0] ex [3] = '{{2'b01,1'b1,1'b1,8'd0}, {2'b00,1'b0,1'b0,8'd0},
                                {2'b00,1'b0,1'b0,8'd0}};
        do_reset();
        len0 = 4'd0;
        len1 = 4'd4;
        for (int i = 0; i < 3; i++) begin
            req = rq[i];
            tick();
            checks++;
            if (obs !== ex[i]) begin
                failures++;
                $display("FAIL zero_len[%0d] got=%h want=%h", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_abort();
        logic [1:0]  rq [8] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b11, 2'b11, 2'b00};
        logic [11:0] ex [8] = '{{2'b01,1'b1,1'b0,8'd0}, {2'b01,1'b1,1'b0,8'd1},
                                {2'b01,1'b1,1'b0,8'd2}, {2'b01,1'b1,1'b0,8'd3},
                                {2'b00,1'b0,1'b0,8'd3}, {2'b10,1'b1,1'b0,8'd3},
                                {2'b10,1'b1,1'b1,8'd2}, {2'b00,1'b0,1'b0,8'd2}};
        do_reset();
        len0 = 4'd8;
        len1 = 4'd1;
        for (int i = 0; i < 8; i++) begin
            req = rq[i];
            tick();
            checks++;
            if (obs !== ex[i]) begin
                failures++;
                $display("FAIL abort[%0d] got=%h want=%h", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [11:0] want;
        do_reset();
        len0 = 4'd8;
        len1 = 4'd8;
        req  = 2'b01;
        for (int i = 0; i < 6; i++) begin
            tick();
            want = {2'b01, 1'b1, 1'b0, 8'(i)};
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL reset_mid_run[%0d] got=%h want=%h", i, obs, want);
            end
        end
        reset = 1'b1;
        tick();
        checks++;
        if (obs !== 12'h000) begin
            failures++;
            $display("FAIL reset_mid_clear got=%h want=%h", obs, 12'h000);
        end
        reset = 1'b0;
        req   = 2'b11;
        tick();
        want = {2'b01, 1'b1, 1'b0, 8'd0};
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL reset_mid_rearb got=%h want=%h", obs, want);
        end
        req = 2'b00;
        tick();
        checks++;
        if (obs !== 12'h000) begin
            failures++;
            $display("FAIL reset_mid_release got=%h want=%h", obs, 12'h000);
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = 2'b00;
        len0  = '0;
        len1  = '0;
        test_reset();
        test_single_up();
        test_fairness();
        test_wrap();
        test_zero_len();
        test_abort();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
